// File: rtl/pipe_ctrl_hazard.sv
// Pipeline control carrier for the 5-stage MIPS core: moves decoded controls through
// ID/EX, EX/MEM and MEM/WB and resolves load-use stalls, redirects and EX forwarding.
module pipe_ctrl_hazard #(
  parameter int REG_ADDR_W = 5,
  parameter int COUNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  mem_to_reg,
  input  logic                  branch,
  input  logic                  jump,
  input  logic                  alu_src,
  input  logic [2:0]            alu_control,
  input  logic                  ex_zero,
  output logic                  stall,
  output logic                  flush_if,
  output logic                  ex_valid,
  output logic                  ex_alu_src,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch,
  output logic [2:0]            ex_alu_control,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  mem_valid,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [REG_ADDR_W-1:0] mem_dest,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [COUNT_W-1:0]    bubble_count
);

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic                  alu_src;
    logic [2:0]            alu_control;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] dest;
  } idex_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_read;
    logic                  mem_write;
    logic [REG_ADDR_W-1:0] dest;
  } exmem_t;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] dest;
  } memwb_t;

  idex_t               idex_q, idex_d;
  exmem_t              exmem_q, exmem_d;
  memwb_t              memwb_q, memwb_d;
  logic [COUNT_W-1:0]  count_q, count_d;

  logic [REG_ADDR_W-1:0] id_dest;
  logic                  rt_used;
  logic                  load_use;
  logic                  br_taken;
  logic                  jump_id;

  assign id_dest  = alu_src ? id_rt : id_rd;
  assign rt_used  = !alu_src | mem_write | branch;
  assign load_use = id_valid & idex_q.valid & idex_q.mem_read & (idex_q.dest != '0) &
                    ((idex_q.dest == id_rs) | (rt_used & (idex_q.dest == id_rt)));
  assign br_taken = idex_q.valid & idex_q.branch & ex_zero;
  assign jump_id  = id_valid & jump;

  assign flush_if = br_taken | (jump_id & !load_use);
  assign stall    = load_use & !br_taken;

  // EX/MEM has priority over MEM/WB because it holds the younger result.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                         input exmem_t m, input memwb_t w);
    if (m.valid && m.reg_write && (m.dest != '0) && (m.dest == src)) return 2'b10;
    if (w.reg_write && (w.dest != '0) && (w.dest == src))            return 2'b01;
    return 2'b00;
  endfunction

  assign fwd_a = fwd_sel(idex_q.rs, exmem_q, memwb_q);
  assign fwd_b = fwd_sel(idex_q.rt, exmem_q, memwb_q);

  always_comb begin
    idex_d = '0;
    if (id_valid && !load_use && !br_taken && !jump_id) begin
      idex_d.valid       = 1'b1;
      idex_d.reg_write   = reg_write & (id_dest != '0);
      idex_d.mem_to_reg  = mem_to_reg;
      idex_d.mem_read    = mem_read;
      idex_d.mem_write   = mem_write;
      idex_d.branch      = branch;
      idex_d.alu_src     = alu_src;
      idex_d.alu_control = alu_control;
      idex_d.rs          = id_rs;
      idex_d.rt          = id_rt;
      idex_d.dest        = id_dest;
    end

    exmem_d.valid      = idex_q.valid;
    exmem_d.reg_write  = idex_q.reg_write;
    exmem_d.mem_to_reg = idex_q.mem_to_reg;
    exmem_d.mem_read   = idex_q.mem_read;
    exmem_d.mem_write  = idex_q.mem_write;
    exmem_d.dest       = idex_q.dest;

    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    memwb_d.dest       = exmem_q.dest;

    // A branch colliding with a load-use produces a single bubble, so count it once.
    count_d = count_q;
    if ((load_use || br_taken) && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      count_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      count_q <= count_d;
    end
  end

  assign ex_valid       = idex_q.valid;
  assign ex_alu_src     = idex_q.alu_src;
  assign ex_mem_read    = idex_q.mem_read;
  assign ex_mem_write   = idex_q.mem_write;
  assign ex_branch      = idex_q.branch;
  assign ex_alu_control = idex_q.alu_control;
  assign ex_rs          = idex_q.rs;
  assign ex_rt          = idex_q.rt;
  assign ex_dest        = idex_q.dest;
  assign mem_valid      = exmem_q.valid;
  assign mem_read_o     = exmem_q.mem_read;
  assign mem_write_o    = exmem_q.mem_write;
  assign mem_dest       = exmem_q.dest;
  assign wb_reg_write   = memwb_q.reg_write;
  assign wb_mem_to_reg  = memwb_q.mem_to_reg;
  assign wb_dest        = memwb_q.dest;
  assign bubble_count   = count_q;

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Bench for pipe_ctrl_hazard: directed MIPS sequences followed by random traffic, all
// compared against a stage-record reference model; narrow counter exposes saturation.
module tb_pipe_ctrl_hazard;
  localparam int AW = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, reg_write, mem_read, mem_write, mem_to_reg, branch, jump, alu_src, ex_zero;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [2:0] alu_control;
  logic stall, flush_if, ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_branch;
  logic [2:0] ex_alu_control;
  logic [AW-1:0] ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
  logic mem_valid, mem_read_o, mem_write_o, wb_reg_write, wb_mem_to_reg;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] bubble_count;

  int nAsserts = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  pipe_ctrl_hazard #(.REG_ADDR_W(AW), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .branch(branch), .jump(jump), .alu_src(alu_src), .alu_control(alu_control), .ex_zero(ex_zero),
    .stall(stall), .flush_if(flush_if), .ex_valid(ex_valid), .ex_alu_src(ex_alu_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_alu_control(ex_alu_control), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .mem_valid(mem_valid), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_dest(mem_dest), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_dest(wb_dest), .fwd_a(fwd_a), .fwd_b(fwd_b), .bubble_count(bubble_count)
  );

  // One record per in-flight instruction; an all-zero record is a bubble.
  typedef struct packed {
    logic       valid, regWrite, memToReg, memRead, memWrite, branch, aluSrc;
    logic [2:0] aluCtl;
    logic [4:0] rs, rt, dest;
  } stage_t;

  stage_t mEx, mMem, mWb;
  int mCnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] refFwd(input logic [4:0] x, input stage_t m, input stage_t w);
    if (m.valid && m.regWrite && m.dest != 0 && m.dest == x) return 2'b10;
    if (w.regWrite && w.dest != 0 && w.dest == x) return 2'b01;
    return 2'b00;
  endfunction

  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic rw, input logic mr,
                               input logic mw, input logic m2r, input logic br, input logic jp,
                               input logic as, input logic [2:0] ac, input logic z,
                               input logic r);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    reg_write = rw; mem_read = mr; mem_write = mw; mem_to_reg = m2r;
    branch = br; jump = jp; alu_src = as; alu_control = ac; ex_zero = z; rst = r;
  endtask

  task automatic checkOutput(input logic expStall, input logic expFlush);
    chk("stall", stall, expStall);
    chk("flush_if", flush_if, expFlush);
    chk("fwd_a", fwd_a, refFwd(mEx.rs, mMem, mWb));
    chk("fwd_b", fwd_b, refFwd(mEx.rt, mMem, mWb));
    chk("ex_valid", ex_valid, mEx.valid);
    chk("ex_alu_src", ex_alu_src, mEx.aluSrc);
    chk("ex_mem_read", ex_mem_read, mEx.memRead);
    chk("ex_mem_write", ex_mem_write, mEx.memWrite);
    chk("ex_branch", ex_branch, mEx.branch);
    chk("ex_alu_control", ex_alu_control, mEx.aluCtl);
    chk("ex_rs", ex_rs, mEx.rs);
    chk("ex_rt", ex_rt, mEx.rt);
    chk("ex_dest", ex_dest, mEx.dest);
    chk("mem_valid", mem_valid, mMem.valid);
    chk("mem_read_o", mem_read_o, mMem.memRead);
    chk("mem_write_o", mem_write_o, mMem.memWrite);
    chk("mem_dest", mem_dest, mMem.dest);
    chk("wb_reg_write", wb_reg_write, mWb.regWrite);
    chk("wb_mem_to_reg", wb_mem_to_reg, mWb.memToReg);
    chk("wb_dest", wb_dest, mWb.dest);
    chk("bubble_count", bubble_count, mCnt);
  endtask

  // Compare this cycle against the model, then clock once and advance the model.
  task automatic step();
    logic [4:0] dst;
    logic rtUsed, loadUse, brTaken, jumpId;
    stage_t nx;
    #1;
    dst     = alu_src ? id_rt : id_rd;
    rtUsed  = !alu_src || mem_write || branch;
    loadUse = id_valid && mEx.valid && mEx.memRead && mEx.dest != 0 &&
              (mEx.dest == id_rs || (rtUsed && mEx.dest == id_rt));
    brTaken = mEx.valid && mEx.branch && ex_zero;
    jumpId  = id_valid && jump;
    checkOutput(loadUse && !brTaken, brTaken || (jumpId && !loadUse));
    nx = '0;
    if (id_valid && !loadUse && !brTaken && !jumpId)
      nx = '{1'b1, reg_write && dst != 0, mem_to_reg, mem_read, mem_write, branch, alu_src,
             alu_control, id_rs, id_rt, dst};
    @(posedge clk);
    if (rst) begin
      mEx = '0; mMem = '0; mWb = '0; mCnt = 0;
    end else begin
      if ((loadUse || brTaken) && mCnt < (1 << CW) - 1) mCnt++;
      mWb = mMem; mMem = mEx; mEx = nx;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1);
    repeat (2) @(negedge clk);
    mEx = '0; mMem = '0; mWb = '0; mCnt = 0;
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_wb_reg_write", wb_reg_write, 0);
    chk("rst_fwd_a", fwd_a, 2'b00);
    chk("rst_fwd_b", fwd_b, 2'b00);
    chk("rst_count", bubble_count, 0);
    step();
    idle(); step();

    // lw $8,0($0) ; add $9,$8,$8
    applyStimulus(1, 0, 8, 0, 1, 1, 0, 1, 0, 0, 1, 3'b010, 0, 0); step();
    applyStimulus(1, 8, 8, 9, 1, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0);
    #1 chk("lw_stall", stall, 1);
    step();
    #1 chk("lw_bubble", ex_valid, 0);
    chk("lw_stall_drop", stall, 0);
    step();
    idle();
    #1 chk("lw_add_ex", ex_valid, 1);
    chk("lw_fwd_a", fwd_a, 2'b01);
    chk("lw_fwd_b", fwd_b, 2'b01);
    chk("lw_count", bubble_count, 1);
    repeat (3) step();

    // addi $8,$0,5 ; add $9,$8,$0
    applyStimulus(1, 0, 8, 0, 1, 0, 0, 0, 0, 0, 1, 3'b010, 0, 0); step();
    applyStimulus(1, 8, 0, 9, 1, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0);
    #1 chk("addi_no_stall", stall, 0);
    step();
    idle();
    #1 chk("addi_fwd_a", fwd_a, 2'b10);
    chk("addi_fwd_b", fwd_b, 2'b00);
    step();

    // beq taken, then beq not taken
    applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0, 3'b110, 0, 0); step();
    applyStimulus(1, 4, 5, 3, 1, 0, 0, 0, 0, 0, 0, 3'b010, 1, 0);
    #1 chk("beq_flush", flush_if, 1);
    chk("beq_stall", stall, 0);
    step();
    idle();
    #1 chk("beq_bubble", ex_valid, 0);
    chk("beq_count", bubble_count, 2);
    step();
    applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0, 3'b110, 0, 0); step();
    applyStimulus(1, 4, 5, 3, 1, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0);
    #1 chk("beq_nt_flush", flush_if, 0);
    step();
    idle();
    #1 chk("beq_nt_ex", ex_valid, 1);
    step();

    // j target
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 0, 0);
    #1 chk("j_flush", flush_if, 1);
    chk("j_stall", stall, 0);
    step();
    idle();
    #1 chk("j_bubble", ex_valid, 0);
    chk("j_count", bubble_count, 2);
    step();

    // addi $0,$0,1 ; add $9,$0,$0
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 3'b010, 0, 0); step();
    applyStimulus(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0); step();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1 chk("zero_fwd_a", fwd_a, 2'b00);
      chk("zero_fwd_b", fwd_b, 2'b00);
      if (i == 1) chk("zero_wb_reg_write", wb_reg_write, 0);
      step();
    end

    // load-branch in EX meets a dependent ID instruction: branch wins, one bubble
    applyStimulus(1, 0, 8, 0, 1, 1, 0, 1, 1, 0, 1, 3'b010, 0, 0); step();
    applyStimulus(1, 8, 1, 2, 1, 0, 0, 0, 0, 0, 0, 3'b010, 1, 0);
    #1 chk("both_stall", stall, 0);
    chk("both_flush", flush_if, 1);
    step();
    idle();
    #1 chk("both_count", bubble_count, 3);
    step();

    // reset mid-flight while a load-use is pending
    applyStimulus(1, 0, 8, 0, 1, 1, 0, 1, 0, 0, 1, 3'b010, 0, 0); step();
    applyStimulus(1, 8, 8, 9, 1, 0, 0, 0, 0, 0, 0, 3'b010, 0, 1); step();
    rst = 0;
    #1 chk("midrst_ex_valid", ex_valid, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_count", bubble_count, 0);
    step();

    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 99) < 85, 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 30,
                    $urandom_range(0, 99) < 15, 1'($urandom), $urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 10, 1'($urandom), 3'($urandom), 1'($urandom),
                    $urandom_range(0, 199) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end
endmodule
